// File: rtl/hsid_sq_df_acc.sv
// Sum-of-squared-differences accumulator over two band FIFOs (pixel vs reference).
// Define HSID_SQ_DF_ACC_STALL_CNT_EN to add the stall_cycles port and its counter.
module hsid_sq_df_acc #(
  parameter int unsigned DATA_WIDTH       = 16,
  parameter int unsigned BAND_COUNT_WIDTH = 8,
  localparam int unsigned ACC_WIDTH       = 2 * DATA_WIDTH + BAND_COUNT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [BAND_COUNT_WIDTH-1:0] band_count,
  input  logic                        clear,
  input  logic                        vctr1_empty,
  input  logic                        vctr2_empty,
  output logic                        vctr1_rd_en,
  output logic                        vctr2_rd_en,
  input  logic [DATA_WIDTH-1:0]       vctr1_data,
  input  logic [DATA_WIDTH-1:0]       vctr2_data,
  output logic [ACC_WIDTH-1:0]        acc_value,
  output logic                        acc_valid,
  output logic                        busy,
`ifdef HSID_SQ_DF_ACC_STALL_CNT_EN
  output logic [15:0]                 stall_cycles,
`endif
  output logic                        band_err
);

  localparam int unsigned SQ_WIDTH = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                      state_q, state_d;
  logic [BAND_COUNT_WIDTH-1:0] band_q;
  logic [BAND_COUNT_WIDTH-1:0] rd_cnt_q;
  logic [BAND_COUNT_WIDTH-1:0] acc_cnt_q;
  logic                        rd_vld_q;
  logic                        sq_vld_q;
  logic [SQ_WIDTH-1:0]         sq_q;
  logic                        rd_en_c;
  logic                        accept_c;
  logic [DATA_WIDTH-1:0]       diff_c;
  logic [SQ_WIDTH-1:0]         sq_c;

  // Next-state and read-issue decode; clear overrides everything.
  always_comb begin
    state_d  = state_q;
    rd_en_c  = 1'b0;
    accept_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (band_count != '0)) begin
          accept_c = 1'b1;
          state_d  = READ;
        end
      end
      READ: begin
        rd_en_c = !vctr1_empty && !vctr2_empty && (rd_cnt_q < band_q);
        if (rd_en_c && ((rd_cnt_q + BAND_COUNT_WIDTH'(1)) == band_q))
          state_d = DRAIN;
      end
      DRAIN: begin
        if (sq_vld_q && ((acc_cnt_q + BAND_COUNT_WIDTH'(1)) == band_q))
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d  = IDLE;
      rd_en_c  = 1'b0;
      accept_c = 1'b0;
    end
  end

  // Absolute difference and exact square of the sample pair returned by the FIFOs.
  always_comb begin
    diff_c = (vctr1_data >= vctr2_data) ? (vctr1_data - vctr2_data)
                                        : (vctr2_data - vctr1_data);
    sq_c   = SQ_WIDTH'(diff_c) * SQ_WIDTH'(diff_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      band_q    <= '0;
      rd_cnt_q  <= '0;
      acc_cnt_q <= '0;
      rd_vld_q  <= 1'b0;
      sq_vld_q  <= 1'b0;
      sq_q      <= '0;
      acc_value <= '0;
      band_err  <= 1'b0;
    end else if (clear) begin
      state_q   <= IDLE;
      band_q    <= '0;
      rd_cnt_q  <= '0;
      acc_cnt_q <= '0;
      rd_vld_q  <= 1'b0;
      sq_vld_q  <= 1'b0;
      sq_q      <= '0;
      acc_value <= '0;
      band_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      band_err <= (state_q == IDLE) && start && (band_count == '0);
      if (accept_c) begin
        band_q    <= band_count;
        rd_cnt_q  <= '0;
        acc_cnt_q <= '0;
        rd_vld_q  <= 1'b0;
        sq_vld_q  <= 1'b0;
        acc_value <= '0;
      end else begin
        // Two-stage pipe: square the returned pair, then accumulate it.
        rd_vld_q <= rd_en_c;
        sq_vld_q <= rd_vld_q;
        if (rd_en_c)  rd_cnt_q <= rd_cnt_q + BAND_COUNT_WIDTH'(1);
        if (rd_vld_q) sq_q     <= sq_c;
        if (sq_vld_q) begin
          acc_value <= acc_value + ACC_WIDTH'(sq_q);
          acc_cnt_q <= acc_cnt_q + BAND_COUNT_WIDTH'(1);
        end
      end
    end
  end

`ifdef HSID_SQ_DF_ACC_STALL_CNT_EN
  // READ cycles lost to an empty FIFO, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (clear || accept_c) begin
      stall_cycles <= '0;
    end else if ((state_q == READ) && (vctr1_empty || vctr2_empty) &&
                 (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

  assign vctr1_rd_en = rd_en_c;
  assign vctr2_rd_en = rd_en_c;
  assign acc_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);

endmodule
